// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: IF/ID register with branch decode and flag bypass; define BRANCH_SQUASH_EN to kill the wrong-path word.
module fetch_decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic [63:0] pc_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        rt_zero,
  input  logic [3:0]  alu_flags,
  input  logic        flags_we,
  output logic [31:0] instr_out,
  output logic [63:0] pc_out,
  output logic        valid_out,
  output logic [25:0] imm26,
  output logic [18:0] imm19,
  output logic        uncondBr,
  output logic        brTaken,
  output logic [3:0]  flags
);
  logic [31:0] instr_q, instr_d;
  logic [63:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [3:0]  flags_q, flags_d;
  logic        is_b, is_cbz, is_blt, n_eff, v_eff, kill;
  always_comb begin
    is_b    = instr_q[31:26] == 6'b000101;
    is_cbz  = instr_q[31:24] == 8'hB4;
    is_blt  = instr_q[31:24] == 8'h54 && instr_q[4:0] == 5'h0B;
    n_eff   = flags_we ? alu_flags[3] : flags_q[3];
    v_eff   = flags_we ? alu_flags[0] : flags_q[0];
    brTaken = valid_q & ~stall & (is_b | (is_cbz & rt_zero) | (is_blt & (n_eff != v_eff)));
`ifdef BRANCH_SQUASH_EN
    kill    = brTaken;
`else
    kill    = 1'b0;
`endif
    instr_d = stall ? instr_q : instr_in;
    pc_d    = stall ? pc_q : pc_in;
    valid_d = ~flush & ~kill & (stall ? valid_q : 1'b1);
    flags_d = (flags_we & valid_q) ? alu_flags : flags_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      flags_q <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      flags_q <= flags_d;
    end
  end
  // Offsets are pre-decremented because fetch has already advanced the PC by one word.
  assign imm26     = instr_q[25:0] - 26'd1;
  assign imm19     = instr_q[23:5] - 19'd1;
  assign uncondBr  = is_b;
  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign valid_out = valid_q;
  assign flags     = flags_q;
endmodule
